// File: rtl/laser_track_filter.sv
// Laser track filter: per-frame outlier gate, shift-based EMA smoothing and
// LOST/TRACK/COAST tracking, with one filtered target per frame over valid/ready.
module laser_track_filter #(
   parameter int ALPHA_SHIFT = 2,
   parameter int MAX_JUMP    = 64,
   parameter int MISS_LIMIT  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        sof,
   input  logic [31:0] laser_xy,
   input  logic        laser_found,
   output logic [31:0] target_xy,
   output logic        target_valid,
   input  logic        target_ready,
   output logic [1:0]  target_state,
   output logic        overrun,
   output logic [15:0] frame_count
);

   localparam logic [1:0] ST_LOST  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_COAST = 2'd2;

   logic [15:0] r_smp_x_p0, r_smp_y_p0;
   logic        r_found_p0;
   logic        r_vld_p0;
   logic        r_frame_seen;

   logic [1:0]  r_state;
   logic [7:0]  r_miss;
   logic [15:0] r_pos_x, r_pos_y;
   logic        r_valid;
   logic        r_overrun;
   logic [15:0] r_frame_count;

   logic        w_frame_evt;
   logic        w_good;
   logic [7:0]  w_miss_inc;
   logic [1:0]  w_nxt_state;
   logic [7:0]  w_nxt_miss;
   logic [15:0] w_nxt_x, w_nxt_y;

   // Floor-shift EMA step; the result stays between old and sample, so 16 bits suffice.
   function automatic logic [15:0] ema_step(input logic [15:0] old_v, input logic [15:0] smp_v);
      logic signed [16:0] delta;
      logic signed [16:0] upd;
      delta = $signed({1'b0, smp_v}) - $signed({1'b0, old_v});
      upd   = $signed({1'b0, old_v}) + (delta >>> ALPHA_SHIFT);
      return upd[15:0];
   endfunction

   function automatic logic within_gate(input logic [15:0] old_v, input logic [15:0] smp_v);
      logic signed [16:0] delta;
      logic [16:0]        mag;
      delta = $signed({1'b0, smp_v}) - $signed({1'b0, old_v});
      mag   = delta[16] ? unsigned'(-delta) : unsigned'(delta);
      return (mag <= 17'(MAX_JUMP));
   endfunction

   assign w_frame_evt = en && sof;
   assign w_miss_inc  = r_miss + 8'd1;

   always_comb begin
      w_good      = r_found_p0 && within_gate(r_pos_x, r_smp_x_p0) && within_gate(r_pos_y, r_smp_y_p0);
      w_nxt_state = r_state;
      w_nxt_miss  = r_miss;
      w_nxt_x     = r_pos_x;
      w_nxt_y     = r_pos_y;
      case (r_state)
         ST_TRACK, ST_COAST: begin
            if (w_good) begin
               w_nxt_x     = ema_step(r_pos_x, r_smp_x_p0);
               w_nxt_y     = ema_step(r_pos_y, r_smp_y_p0);
               w_nxt_state = ST_TRACK;
               w_nxt_miss  = 8'd0;
            end else begin
               w_nxt_miss  = w_miss_inc;
               w_nxt_state = (w_miss_inc == 8'(MISS_LIMIT)) ? ST_LOST : ST_COAST;
            end
         end
         default: begin
            if (r_found_p0) begin
               w_nxt_x     = r_smp_x_p0;
               w_nxt_y     = r_smp_y_p0;
               w_nxt_state = ST_TRACK;
               w_nxt_miss  = 8'd0;
            end
         end
      endcase
   end

   // Stage 0: capture the detector result at the frame boundary
   always_ff @(posedge clk) begin
      if (w_frame_evt) begin
         r_smp_x_p0 <= laser_xy[31:16];
         r_smp_y_p0 <= laser_xy[15:0];
         r_found_p0 <= laser_found;
      end
   end

   // Stage 1: evaluate the captured sample and drive the handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p0      <= 1'b0;
         r_frame_seen  <= 1'b0;
         r_state       <= ST_LOST;
         r_miss        <= 8'd0;
         r_pos_x       <= 16'd0;
         r_pos_y       <= 16'd0;
         r_valid       <= 1'b0;
         r_overrun     <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_vld_p0  <= w_frame_evt && r_frame_seen;
         r_overrun <= r_vld_p0 && r_valid && !target_ready;
         if (w_frame_evt) r_frame_seen <= 1'b1;
         if (r_vld_p0) begin
            r_state       <= w_nxt_state;
            r_miss        <= w_nxt_miss;
            r_pos_x       <= w_nxt_x;
            r_pos_y       <= w_nxt_y;
            r_valid       <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
         end else if (r_valid && target_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign target_xy    = {r_pos_x, r_pos_y};
   assign target_valid = r_valid;
   assign target_state = r_state;
   assign overrun      = r_overrun;
   assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_laser_track_filter.sv
// Bench for laser_track_filter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_laser_track_filter;

   localparam int ALPHA = 2;
   localparam int JUMP  = 64;
   localparam int MLIM  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        sof = 1'b0;
   logic [31:0] laser_xy = 32'd0;
   logic        laser_found = 1'b0;
   logic        target_ready = 1'b1;
   logic [31:0] target_xy;
   logic        target_valid;
   logic [1:0]  target_state;
   logic        overrun;
   logic [15:0] frame_count;

   int n_vec = 0;
   int n_err = 0;

   laser_track_filter #(.ALPHA_SHIFT(ALPHA), .MAX_JUMP(JUMP), .MISS_LIMIT(MLIM)) dut (
      .clk(clk), .reset(reset), .en(en), .sof(sof), .laser_xy(laser_xy),
      .laser_found(laser_found), .target_xy(target_xy), .target_valid(target_valid),
      .target_ready(target_ready), .target_state(target_state), .overrun(overrun),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: integer positions, pending sample list, plain arithmetic.
   int          m_x, m_y, m_state, m_miss;
   bit          m_valid, m_ovr, m_seen, m_live;
   logic [15:0] m_fc;
   int          q_x[$], q_y[$];
   bit          q_f[$];

   function automatic int floor_div_pow2(input int d, input int sh);
      int p;
      p = 1 << sh;
      if (d >= 0) return d / p;
      return -((-d + p - 1) / p);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_eval(input int sx, input int sy, input bit f);
      bit good;
      good = f && iabs(sx - m_x) <= JUMP && iabs(sy - m_y) <= JUMP;
      if (m_state == 0) begin
         if (f) begin m_x = sx; m_y = sy; m_state = 1; m_miss = 0; end
      end else if (good) begin
         m_x = m_x + floor_div_pow2(sx - m_x, ALPHA);
         m_y = m_y + floor_div_pow2(sy - m_y, ALPHA);
         m_state = 1; m_miss = 0;
      end else begin
         m_miss = m_miss + 1;
         m_state = (m_miss >= MLIM) ? 0 : 2;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_x = 0; m_y = 0; m_state = 0; m_miss = 0;
         m_valid = 0; m_ovr = 0; m_seen = 0; m_fc = 16'd0; m_live = 1;
         q_x.delete(); q_y.delete(); q_f.delete();
      end else if (m_live) begin
         bit accept;
         accept = m_valid && target_ready;
         m_ovr = 0;
         if (q_x.size() > 0) begin
            if (m_valid && !target_ready) m_ovr = 1;
            model_eval(q_x.pop_front(), q_y.pop_front(), q_f.pop_front());
            m_fc = m_fc + 16'd1;
            m_valid = 1;
         end else if (accept) begin
            m_valid = 0;
         end
         if (en && sof) begin
            if (m_seen) begin
               q_x.push_back(int'(laser_xy[31:16]));
               q_y.push_back(int'(laser_xy[15:0]));
               q_f.push_back(laser_found);
            end
            m_seen = 1;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         logic [31:0] exp_xy;
         exp_xy = {m_x[15:0], m_y[15:0]};
         n_vec++;
         if (target_xy !== exp_xy || target_valid !== m_valid || target_state !== 2'(m_state)
             || overrun !== m_ovr || frame_count !== m_fc) begin
            n_err++;
            $display("FAIL model_cmp t=%0t xy=%h exp %h valid=%b exp %b state=%0d exp %0d ovr=%b exp %b fc=%0d exp %0d",
                     $time, target_xy, exp_xy, target_valid, m_valid, target_state, m_state,
                     overrun, m_ovr, frame_count, m_fc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Frame event at the current negedge; returns two negedges later, just after evaluation.
   task automatic frame(input bit f, input int x, input int y, input bit rdy_after);
      en = 1'b1; sof = 1'b1; laser_found = f; laser_xy = {x[15:0], y[15:0]};
      @(negedge clk);
      sof = 1'b0; laser_found = 1'b0; laser_xy = 32'd0; target_ready = rdy_after;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int clamp16(input int v);
      if (v < 0) return 0;
      if (v > 65535) return 65535;
      return v;
   endfunction

   initial begin
      int bx, by;
      @(negedge clk);
      do_reset();
      chk("rst_valid", 32'(target_valid), 32'd0);
      chk("rst_xy", target_xy, 32'd0);
      chk("rst_state", 32'(target_state), 32'd0);
      chk("rst_fc", 32'(frame_count), 32'd0);

      frame(1, 100, 50, 1);
      chk("first_frame_no_valid", 32'(target_valid), 32'd0);
      frame(1, 100, 50, 1);
      chk("acq_xy", target_xy, {16'd100, 16'd50});
      chk("acq_state", 32'(target_state), 32'd1);
      chk("acq_valid", 32'(target_valid), 32'd1);
      chk("acq_fc", 32'(frame_count), 32'd1);

      frame(1, 120, 46, 1);
      chk("ema_xy", target_xy, {16'd105, 16'd49});
      frame(1, 105, 49, 1);
      chk("ema_hold_xy", target_xy, {16'd105, 16'd49});

      frame(1, 300, 49, 1);
      chk("gate_xy", target_xy, {16'd105, 16'd49});
      chk("gate_state", 32'(target_state), 32'd2);
      frame(1, 108, 49, 1);
      chk("regain_xy", target_xy, {16'd105, 16'd49});
      chk("regain_state", 32'(target_state), 32'd1);

      frame(0, 0, 0, 1);
      chk("miss1_state", 32'(target_state), 32'd2);
      frame(0, 0, 0, 1);
      chk("miss2_state", 32'(target_state), 32'd2);
      frame(0, 0, 0, 1);
      chk("lost_state", 32'(target_state), 32'd0);
      chk("lost_xy", target_xy, {16'd105, 16'd49});
      frame(1, 400, 300, 1);
      chk("reacq_xy", target_xy, {16'd400, 16'd300});
      chk("reacq_state", 32'(target_state), 32'd1);

      @(negedge clk);
      target_ready = 1'b0;
      frame(1, 404, 300, 0);
      chk("bp_first_valid", 32'(target_valid), 32'd1);
      chk("bp_first_ovr", 32'(overrun), 32'd0);
      frame(1, 408, 304, 0);
      chk("bp_overwrite_xy", target_xy, {16'd402, 16'd301});
      chk("bp_ovr_pulse", 32'(overrun), 32'd1);
      @(negedge clk);
      chk("bp_ovr_clear", 32'(overrun), 32'd0);
      frame(1, 402, 301, 1);
      chk("acc_eval_valid", 32'(target_valid), 32'd1);
      chk("acc_eval_ovr", 32'(overrun), 32'd0);
      @(negedge clk);
      chk("accept_drop", 32'(target_valid), 32'd0);

      frame(0, 0, 0, 0);
      chk("pre_rst_state", 32'(target_state), 32'd2);
      chk("pre_rst_valid", 32'(target_valid), 32'd1);
      do_reset();
      chk("mid_rst_valid", 32'(target_valid), 32'd0);
      chk("mid_rst_state", 32'(target_state), 32'd0);
      chk("mid_rst_xy", target_xy, 32'd0);
      target_ready = 1'b1;
      frame(1, 10, 10, 1);
      chk("post_rst_first", 32'(target_valid), 32'd0);
      chk("post_rst_fc", 32'(frame_count), 32'd0);

      en = 1'b0; sof = 1'b1; laser_found = 1'b1;
      @(negedge clk); @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
      chk("en0_ignored", 32'(target_valid), 32'd0);

      bx = 1000; by = 800;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0) begin bx = $urandom_range(0, 65535); by = $urandom_range(0, 65535); end
         reset        = ($urandom_range(0, 599) == 0);
         en           = ($urandom_range(0, 7) != 0);
         sof          = ($urandom_range(0, 2) == 0);
         laser_found  = ($urandom_range(0, 4) != 0);
         laser_xy     = {16'(clamp16(bx + $urandom_range(0, 180) - 90)),
                         16'(clamp16(by + $urandom_range(0, 180) - 90))};
         target_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      reset = 1'b0; en = 1'b0; sof = 1'b0; target_ready = 1'b1;
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
